// File: rtl/multi_fade.sv
// Multi-channel LED fader: shared prescaler, step counter and PWM counter drive
// per-channel INC/HIGH/DEC/LOW fade states. Optional pause input via MULTI_FADE_PAUSE_EN.
module multi_fade #(
    parameter int NUM_CH           = 3,
    parameter int PWM_INTERVAL     = 1200,
    parameter int INC_DEC_INTERVAL = 10000,
    parameter int INC_DEC_MAX      = 200,
    parameter int INC_DEC_VAL      = PWM_INTERVAL / INC_DEC_MAX,
    parameter logic [2*NUM_CH-1:0] START_STATES = (2*NUM_CH)'(6'b11_10_00),
    localparam int W = $clog2(PWM_INTERVAL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
`ifdef MULTI_FADE_PAUSE_EN
    input  logic                pause,
`endif
    output logic [NUM_CH-1:0]   pwm_out,
    output logic [NUM_CH*W-1:0] level,
    output logic                tick
);

    localparam int PSW = $clog2(INC_DEC_INTERVAL + 1);
    localparam int SW  = $clog2(INC_DEC_MAX + 1);

    localparam logic [PSW-1:0] PRESC_LAST = PSW'(INC_DEC_INTERVAL - 1);
    localparam logic [SW-1:0]  STEP_LAST  = SW'(INC_DEC_MAX - 1);
    localparam logic [W-1:0]   PWM_LAST   = W'(PWM_INTERVAL - 1);
    localparam logic [W:0]     LVL_MAX    = (W+1)'(PWM_INTERVAL - 1);
    localparam logic [W:0]     STEP_VAL   = (W+1)'(INC_DEC_VAL);

    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_OFF    = 2'b01;
    localparam logic [1:0] MODE_ON     = 2'b10;

    localparam logic [1:0] ST_INC  = 2'b00;
    localparam logic [1:0] ST_HIGH = 2'b01;
    localparam logic [1:0] ST_DEC  = 2'b10;

    logic [PSW-1:0]      presc;
    logic [SW-1:0]       step_count;
    logic [W-1:0]        pwm_count;
    logic [2*NUM_CH-1:0] state;
    logic [W-1:0]        lvl      [NUM_CH];
    logic [W-1:0]        lvl_next [NUM_CH];
    logic [W:0]          inc_sum  [NUM_CH];
    logic                presc_en;

`ifdef MULTI_FADE_PAUSE_EN
    assign presc_en = ~pause;
`else
    assign presc_en = 1'b1;
`endif

    // Next level for a RUN tick, computed one bit wider so saturation cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            inc_sum[i]  = {1'b0, lvl[i]} + STEP_VAL;
            lvl_next[i] = lvl[i];
            case (state[2*i +: 2])
                ST_INC:  lvl_next[i] = (inc_sum[i] > LVL_MAX) ? LVL_MAX[W-1:0] : inc_sum[i][W-1:0];
                ST_HIGH: lvl_next[i] = LVL_MAX[W-1:0];
                ST_DEC:  lvl_next[i] = ({1'b0, lvl[i]} < STEP_VAL) ? '0 : lvl[i] - STEP_VAL[W-1:0];
                default: lvl_next[i] = '0;
            endcase
        end
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            level[W*i +: W] = lvl[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            tick       <= 1'b0;
            step_count <= '0;
            pwm_count  <= '0;
            pwm_out    <= '0;
            state      <= START_STATES;
            for (int i = 0; i < NUM_CH; i++) begin
                lvl[i] <= '0;
            end
        end else begin
            if (presc_en) begin
                tick  <= (presc == PRESC_LAST);
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end else begin
                tick  <= 1'b0;
            end

            pwm_count <= (pwm_count == PWM_LAST) ? '0 : pwm_count + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= (pwm_count < lvl[i]);
            end

            // Level update and state advance both read the pre-tick state.
            case (mode)
                MODE_RUN: begin
                    if (tick) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            lvl[i] <= lvl_next[i];
                        end
                        if (step_count == STEP_LAST) begin
                            step_count <= '0;
                            for (int i = 0; i < NUM_CH; i++) begin
                                state[2*i +: 2] <= state[2*i +: 2] + 2'd1;
                            end
                        end else begin
                            step_count <= step_count + 1'b1;
                        end
                    end
                end
                MODE_OFF: begin
                    step_count <= '0;
                    state      <= START_STATES;
                    for (int i = 0; i < NUM_CH; i++) begin
                        lvl[i] <= '0;
                    end
                end
                MODE_ON: begin
                    step_count <= '0;
                    state      <= START_STATES;
                    for (int i = 0; i < NUM_CH; i++) begin
                        lvl[i] <= LVL_MAX[W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_fade.sv
// Bench for multi_fade: directed fade/mode/reset/pause steps plus random mode
// sequences, all checked every cycle against an integer reference model.
module tb_multi_fade;
    localparam int NCH = 3;
    localparam int PI  = 12;
    localparam int IDI = 4;
    localparam int MAX = 4;
    localparam int VAL = 3;
    localparam logic [5:0] START = 6'b11_10_00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        pause = 1'b0;
    logic [2:0]  pwm_out;
    logic [11:0] level;
    logic        tick;

    int tests = 0;
    int fails = 0;

    // Reference model: plain integers, stepped once per clock edge.
    int m_lvl[NCH];
    int m_st[NCH];
    int m_pwm[NCH];
    int m_presc, m_tick, m_step, m_pwmc;

    multi_fade #(
        .NUM_CH(NCH), .PWM_INTERVAL(PI), .INC_DEC_INTERVAL(IDI),
        .INC_DEC_MAX(MAX), .INC_DEC_VAL(VAL), .START_STATES(START)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
`ifdef MULTI_FADE_PAUSE_EN
        .pause(pause),
`endif
        .pwm_out(pwm_out),
        .level(level),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_level();
        logic [11:0] r;
        for (int i = 0; i < NCH; i++) r[4*i +: 4] = 4'(m_lvl[i]);
        return r;
    endfunction

    function automatic logic [2:0] exp_pwm();
        logic [2:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_pwm[i] != 0);
        return r;
    endfunction

    function automatic logic [5:0] exp_state();
        logic [5:0] r;
        for (int i = 0; i < NCH; i++) r[2*i +: 2] = 2'(m_st[i]);
        return r;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_presc = 0; m_tick = 0; m_step = 0; m_pwmc = 0;
            for (int i = 0; i < NCH; i++) begin
                m_lvl[i] = 0; m_pwm[i] = 0; m_st[i] = int'(START[2*i +: 2]);
            end
        end else begin
            for (int i = 0; i < NCH; i++) m_pwm[i] = (m_pwmc < m_lvl[i]) ? 1 : 0;
            m_pwmc = (m_pwmc + 1) % PI;
            if (mode == 2'b00 && m_tick != 0) begin
                for (int i = 0; i < NCH; i++) begin
                    case (m_st[i])
                        0:       m_lvl[i] = (m_lvl[i] + VAL > PI - 1) ? PI - 1 : m_lvl[i] + VAL;
                        1:       m_lvl[i] = PI - 1;
                        2:       m_lvl[i] = (m_lvl[i] - VAL < 0) ? 0 : m_lvl[i] - VAL;
                        default: m_lvl[i] = 0;
                    endcase
                end
                m_step++;
                if (m_step == MAX) begin
                    m_step = 0;
                    for (int i = 0; i < NCH; i++) m_st[i] = (m_st[i] + 1) % 4;
                end
            end else if (mode == 2'b01 || mode == 2'b10) begin
                m_step = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_lvl[i] = (mode == 2'b10) ? PI - 1 : 0;
                    m_st[i]  = int'(START[2*i +: 2]);
                end
            end
            if (pause == 1'b0) begin
                m_tick  = (m_presc == IDI - 1) ? 1 : 0;
                m_presc = (m_presc + 1) % IDI;
            end else begin
                m_tick = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("level", 32'(level), 32'(exp_level()));
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm()));
        check("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick !== 1'b1 && n < 4 * IDI);
        check("tick_arrives", 32'(tick), 32'd1);
    endtask

    int ch0_tab[9] = '{3, 6, 9, 11, 11, 11, 11, 11, 8};
    int ch1_tab[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 3};
    int ch2_tab[9] = '{0, 0, 0, 0, 3, 6, 9, 11, 11};

    initial begin
        int n, highs, ticks, toggles, tick_seen, p, r, len;
        logic prev;

        // Reset state
        rst = 1'b1; mode = 2'b00;
        cycle(); cycle();
        check("rst_level", 32'(level), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_state", 32'(dut.state), 32'(START));
        rst = 1'b0;

        // RUN: nine ticks of the fade pattern from START
        for (int k = 0; k < 9; k++) begin
            wait_tick(n);
            check("tick_period", 32'(n), 32'((k == 0) ? IDI : IDI - 1));
            cycle();
            check("run_ch0", 32'(level[3:0]), 32'(ch0_tab[k]));
            check("run_ch1", 32'(level[7:4]), 32'(ch1_tab[k]));
            check("run_ch2", 32'(level[11:8]), 32'(ch2_tab[k]));
            if (k == 3) check("ch0_high", 32'(dut.state[1:0]), 32'd1);
        end

        // FREEZE at ch0 level 6
        rst = 1'b1; cycle(); rst = 1'b0;
        wait_tick(n); cycle(); wait_tick(n); cycle();
        check("frz_ch0", 32'(level[3:0]), 32'd6);
        mode = 2'b11;
        highs = 0;
        repeat (PI) begin
            cycle();
            highs += int'(pwm_out[0]);
        end
        check("frz_duty", 32'(highs), 32'd6);
        ticks = 0;
        repeat (8 * IDI) begin
            cycle();
            ticks += int'(tick);
        end
        check("frz_ticks", 32'(ticks), 32'd8);
        check("frz_hold", 32'(level[3:0]), 32'd6);

        // ALL_ON mid-fade, then back to RUN
        mode = 2'b00;
        repeat ($urandom_range(5, 20)) cycle();
        mode = 2'b10;
        cycle();
        check("on_level", 32'(level), 32'hBBB);
        repeat (3) cycle();
        check("on_state", 32'(dut.state), 32'(START));
        check("on_step", 32'(dut.step_count), 32'd0);
        if (tick === 1'b1) cycle();
        mode = 2'b00;
        wait_tick(n);
        cycle();
        check("on_first_upd", 32'(level), 32'h08B);

        // Reset mid-PWM-period with nonzero levels
        repeat ($urandom_range(3, 9)) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_pwm", 32'(pwm_out), 32'd0);
        check("mid_rst_tick", 32'(tick), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(START));

`ifdef MULTI_FADE_PAUSE_EN
        // Pause: prescaler frozen, PWM keeps running
        wait_tick(n); cycle(); wait_tick(n); cycle();
        repeat ($urandom_range(0, 2)) cycle();
        if (tick === 1'b1) cycle();
        pause = 1'b1;
        toggles = 0; tick_seen = 0; prev = pwm_out[0];
        repeat (20) begin
            cycle();
            tick_seen |= int'(tick);
            if (pwm_out[0] !== prev) toggles++;
            prev = pwm_out[0];
        end
        check("pause_no_tick", 32'(tick_seen), 32'd0);
        check("pause_level", 32'(level), 32'h006);
        check("pause_toggle", 32'(toggles > 0), 32'd1);
        p = m_presc;
        pause = 1'b0;
        wait_tick(n);
        check("pause_resume", 32'(n), 32'(IDI - p));
`endif

        // Random mode/reset/pause sequences
        for (int s = 0; s < 80; s++) begin
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 2'b00 : 2'(r - 6);
`ifdef MULTI_FADE_PAUSE_EN
            pause = ($urandom_range(0, 4) == 0);
`endif
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; cycle(); rst = 1'b0;
            end
            len = $urandom_range(1, 30);
            repeat (len) cycle();
        end
        pause = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
